truth_table_sequencer: RTL and testbench



---
 rtl/truth_table_sequencer.sv | 136 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Stimulus/capture sequencer for a 3-input gate: walks rows 000..111, samples the
// gate output after a settle interval and compares the captured word to EXPECTED.
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h4F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_word,
    output logic       match,
    output logic [7:0] mismatch
);

    localparam int unsigned ROW_W   = 3;
    localparam int unsigned COUNT_W = 8;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(7);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   row, row_d;
    logic [COUNT_W-1:0] count, count_d;
    logic [7:0]         table_d;
    logic [7:0]         mismatch_d;
    logic               match_d;
    logic               drive_row_d;

    // State register; outputs are registered from the next-state values so they
    // line up with the state they belong to and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            count      <= '0;
            table_word <= '0;
            match      <= 1'b0;
            mismatch   <= '0;
            {in1, in2, in3} <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            count      <= count_d;
            table_word <= table_d;
            match      <= match_d;
            mismatch   <= mismatch_d;
            {in1, in2, in3} <= drive_row_d ? row_d : ROW_W'(0);
            busy       <= drive_row_d;
            done       <= (state_d == DONE);
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        state_d    = state;
        row_d      = row;
        count_d    = count;
        table_d    = table_word;
        match_d    = match;
        mismatch_d = mismatch;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    table_d    = '0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                    row_d      = '0;
                    count_d    = '0;
                    state_d    = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d    = IDLE;
                    row_d      = '0;
                    count_d    = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                end else begin
                    count_d = count + COUNT_W'(1);
                    if (count == LAST_COUNT) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d    = IDLE;
                    row_d      = '0;
                    count_d    = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                end else begin
                    // Row 000 lands in the MSB to match the hex naming of gates.
                    table_d[LAST_ROW - row] = gate_out;
                    if (row == LAST_ROW) begin
                        state_d    = DONE;
                        match_d    = (table_d == EXPECTED);
                        mismatch_d = table_d ^ EXPECTED;
                    end else begin
                        row_d   = row + ROW_W'(1);
                        count_d = '0;
                        state_d = APPLY;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign drive_row_d = (state_d == APPLY) || (state_d == SAMPLE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a 0x4F gate model or tied output feeds
// gate_out; one instance with SETTLE_CYCLES=4 and one with SETTLE_CYCLES=1.
module tb_truth_table_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       gate_out;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] table_word, mismatch;

    logic       start_b;
    logic       abort_b;
    logic       gate_out_b;
    logic       in1_b, in2_b, in3_b, busy_b, done_b, match_b;
    logic [7:0] table_word_b, mismatch_b;

    logic [7:0] model_tt;
    logic [1:0] mode;   // 0: 0x4F gate model, 1: tied 0, 2: tied 1
    int         tests;
    int         fails;

    truth_table_sequencer #(.SETTLE_CYCLES(4), .EXPECTED(8'h4F)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .gate_out(gate_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .table_word(table_word), .match(match), .mismatch(mismatch)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(8'h4F)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .gate_out(gate_out_b),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b), .done(done_b),
        .table_word(table_word_b), .match(match_b), .mismatch(mismatch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 0x4F gate: out for row r is bit (7-r) of the word.
    always_comb begin
        model_tt   = 8'h4F;
        gate_out   = (mode == 2'd0) ? model_tt[3'd7 - {in1, in2, in3}] : (mode == 2'd2);
        gate_out_b = model_tt[3'd7 - {in1_b, in2_b, in3_b}];
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Observed {in1,in2,in3,busy,done} of instance A.
    function automatic logic [7:0] ctl_a();
        return {3'b000, in1, in2, in3, busy, done};
    endfunction

    task automatic sweep_a(input logic [7:0] exp_word, input logic [7:0] exp_match,
                           input logic [7:0] exp_mis, input logic repulse);
        logic [7:0] exp_ctl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            if (c <= 40) exp_ctl = {3'b000, 3'((c - 1) / 5), 2'b10};
            else         exp_ctl = 8'b0000_0001;
            check($sformatf("sweep_ctl_c%0d", c), ctl_a(), exp_ctl);
            start = repulse && (c == 10 || c == 41);
            if (c < 41) @(negedge clk);
        end
        check("sweep_word", table_word, exp_word);
        check("sweep_match", {7'd0, match}, exp_match);
        check("sweep_mismatch", mismatch, exp_mis);
        @(negedge clk);
        start = 1'b0;
        check("after_done_ctl", ctl_a(), 8'h00);
        check("after_done_word", table_word, exp_word);
        check("after_done_match", {7'd0, match}, exp_match);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mode    = 2'd0;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ctl", ctl_a(), 8'h00);
        check("rst_word", table_word, 8'h00);
        check("rst_match", {7'd0, match}, 8'h00);
        check("rst_mismatch", mismatch, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctl", ctl_a(), 8'h00);

        // Gate model, with start re-pulsed mid-sweep and in the DONE cycle
        sweep_a(8'h4F, 8'h01, 8'h00, 1'b1);

        mode = 2'd1;
        sweep_a(8'h00, 8'h00, 8'h4F, 1'b0);
        mode = 2'd2;
        sweep_a(8'hFF, 8'h00, 8'hB0, 1'b0);
        mode = 2'd0;

        // Abort while row 3 is in APPLY (row 3 covers cycles 16..20)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_abort_ctl", ctl_a(), 8'b0000_1110);
        check("pre_abort_word", table_word, 8'h40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctl", ctl_a(), 8'h00);
        check("abort_word", table_word, 8'h00);
        check("abort_match", {7'd0, match}, 8'h00);
        check("abort_mismatch", mismatch, 8'h00);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_%0d", i), ctl_a(), 8'h00);
        end
        sweep_a(8'h4F, 8'h01, 8'h00, 1'b0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_ctl", ctl_a(), 8'h00);
        @(negedge clk);
        check("start_abort_ctl2", ctl_a(), 8'h00);
        check("start_abort_word", table_word, 8'h4F);

        // Reset mid-sweep while row 5 is driven (cycles 26..30)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        check("pre_reset_ctl", ctl_a(), 8'b0001_0110);
        check("pre_reset_word", table_word, 8'h48);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_ctl", ctl_a(), 8'h00);
        check("mid_reset_word", table_word, 8'h00);
        check("mid_reset_match", {7'd0, match}, 8'h00);
        check("mid_reset_mismatch", mismatch, 8'h00);
        @(negedge clk);
        sweep_a(8'h4F, 8'h01, 8'h00, 1'b0);

        // SETTLE_CYCLES=1 instance: 2 cycles per row, done in cycle 17
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            logic [7:0] exp_b;
            if (c <= 16) exp_b = {3'b000, 3'((c - 1) / 2), 2'b10};
            else         exp_b = 8'b0000_0001;
            check($sformatf("b_ctl_c%0d", c),
                  {3'b000, in1_b, in2_b, in3_b, busy_b, done_b}, exp_b);
            if (c < 17) @(negedge clk);
        end
        check("b_word", table_word_b, 8'h4F);
        check("b_match", {7'd0, match_b}, 8'h01);
        check("b_mismatch", mismatch_b, 8'h00);
        @(negedge clk);
        check("b_after_done", {3'b000, in1_b, in2_b, in3_b, busy_b, done_b}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
